sort_scheduler: RTL and testbench

SORT_SCHEDULER -- requirements
Module: sort_scheduler

---
 rtl/sort_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_sort_scheduler.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_scheduler.sv
// Sort job sequencer: feeds NCHUNK chunks through the sorting network into the input modules, then drains TOTAL merged words.
// Stalls in LOAD until chunk_valid. Stalls in DRAIN while t_empty. A watchdog aborts SORT/ROUTE waits that exceed TIMEOUT.
module sort_scheduler #(
   parameter int NCHUNK  = 8,
   parameter int CHUNK_W = 512,
   parameter int TOTAL   = 128,
   parameter int TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               chunk_valid,
   input  logic [CHUNK_W-1:0] chunk_data,
   output logic               chunk_ready,
   output logic [CHUNK_W-1:0] s_din,
   output logic               s_ena,
   input  logic               s_valid,
   output logic [NCHUNK-1:0]  im_ena,
   input  logic [NCHUNK-1:0]  im_done,
   output logic               t_deq,
   input  logic               t_empty,
   output logic [7:0]         out_cnt,
   output logic               started,
   output logic               finished,
   output logic               busy,
   output logic               err
);

   localparam int IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);
   localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT - 1);
   localparam logic [7:0]       TOTAL_C  = 8'(TOTAL);
   localparam logic [NCHUNK-1:0] ONE_HOT0 = NCHUNK'(1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SORT,
      ROUTE,
      DRAIN,
      DONE
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [IDX_W-1:0]  idx;
   logic [WD_W-1:0]   wdog;

   logic job_clear;
   logic load_fire;
   logic sort_fire;
   logic route_fire;
   logic wd_expire;
   logic wd_at_limit;
   logic wd_enter;

   assign wd_at_limit = (wdog == WD_LIMIT);
   assign wd_enter    = ((state_nxt == SORT)  && (state != SORT)) ||
                        ((state_nxt == ROUTE) && (state != ROUTE));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      chunk_ready = 1'b0;
      t_deq       = 1'b0;
      busy        = 1'b0;
      finished    = 1'b0;
      job_clear   = 1'b0;
      load_fire   = 1'b0;
      sort_fire   = 1'b0;
      route_fire  = 1'b0;
      wd_expire   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               job_clear = 1'b1;
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            busy        = 1'b1;
            chunk_ready = 1'b1;
            if (chunk_valid) begin
               load_fire = 1'b1;
               state_nxt = SORT;
            end
         end
         SORT: begin
            busy = 1'b1;
            if (s_valid) begin
               sort_fire = 1'b1;
               state_nxt = ROUTE;
            end else if (wd_at_limit) begin
               wd_expire = 1'b1;
               state_nxt = DONE;
            end
         end
         ROUTE: begin
            busy = 1'b1;
            if (im_done[idx]) begin
               route_fire = 1'b1;
               state_nxt  = (idx == LAST_IDX) ? DRAIN : LOAD;
            end else if (wd_at_limit) begin
               wd_expire = 1'b1;
               state_nxt = DONE;
            end
         end
         DRAIN: begin
            busy = 1'b1;
            if (out_cnt >= TOTAL_C) begin
               state_nxt = DONE;
            end else begin
               t_deq = !t_empty;
               // Leave on the same cycle the last word is dequeued so DONE never sees t_deq
               if (t_deq && (out_cnt == TOTAL_C - 8'd1)) begin
                  state_nxt = DONE;
               end
            end
         end
         DONE: begin
            finished = 1'b1;
            if (start) begin
               job_clear = 1'b1;
               state_nxt = LOAD;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx     <= '0;
         s_din   <= '0;
         s_ena   <= 1'b0;
         im_ena  <= '0;
         out_cnt <= '0;
         started <= 1'b0;
         err     <= 1'b0;
         wdog    <= '0;
      end else begin
         s_ena <= load_fire;
         if (load_fire) begin
            s_din <= chunk_data;
         end

         if (job_clear) begin
            idx     <= '0;
            out_cnt <= '0;
            started <= 1'b0;
            err     <= 1'b0;
         end

         if (sort_fire) begin
            im_ena <= ONE_HOT0 << idx;
         end else if (route_fire) begin
            im_ena <= '0;
            if (idx != LAST_IDX) begin
               idx <= idx + 1'b1;
            end
         end else if (wd_expire) begin
            im_ena <= '0;
            err    <= 1'b1;
         end

         if (t_deq) begin
            started <= 1'b1;
            if (out_cnt != 8'hFF) begin
               out_cnt <= out_cnt + 8'd1;
            end
         end

         if (wd_enter) begin
            wdog <= '0;
         end else if ((state == SORT) || (state == ROUTE)) begin
            wdog <= wdog + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sort_scheduler.sv
// Randomized bench for sort_scheduler: behavioural sorter / input-module / merge-tree responders plus a job-level model.
module tb_sort_scheduler;

   localparam int NCHUNK  = 8;
   localparam int CHUNK_W = 512;
   localparam int TOTAL   = 128;
   localparam int TIMEOUT = 255;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic               chunk_valid;
   logic [CHUNK_W-1:0] chunk_data;
   logic               chunk_ready;
   logic [CHUNK_W-1:0] s_din;
   logic               s_ena;
   logic               s_valid;
   logic [NCHUNK-1:0]  im_ena;
   logic [NCHUNK-1:0]  im_done;
   logic               t_deq;
   logic               t_empty;
   logic [7:0]         out_cnt;
   logic               started;
   logic               finished;
   logic               busy;
   logic               err;

   int errors = 0;
   int checks = 0;

   sort_scheduler #(
      .NCHUNK (NCHUNK),
      .CHUNK_W(CHUNK_W),
      .TOTAL  (TOTAL),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .chunk_valid(chunk_valid),
      .chunk_data (chunk_data),
      .chunk_ready(chunk_ready),
      .s_din      (s_din),
      .s_ena      (s_ena),
      .s_valid    (s_valid),
      .im_ena     (im_ena),
      .im_done    (im_done),
      .t_deq      (t_deq),
      .t_empty    (t_empty),
      .out_cnt    (out_cnt),
      .started    (started),
      .finished   (finished),
      .busy       (busy),
      .err        (err)
   );

   always #5 clk = ~clk;

   // Observations gathered by drive_job, judged by each test task
   int obs_sena, obs_tdeq, obs_din_bad, obs_onehot_bad, obs_overlap, obs_tdeq_bad;
   int obs_cnt_bad, obs_started_bad, obs_busy_bad, obs_first_stall, obs_stall_sena;
   int obs_stray_bad, obs_stray_checked, obs_to_cycles, obs_rst_seen, obs_cnt_pre_rst;
   int obs_timed_out;
   logic obs_rst_nonzero;
   logic [NCHUNK-1:0]  obs_im_seq[$];
   logic [CHUNK_W-1:0] last_chunk;

   function automatic logic [CHUNK_W-1:0] rand_chunk();
      logic [CHUNK_W-1:0] v;
      for (int w = 0; w < CHUNK_W / 32; w++) v[w*32 +: 32] = $urandom;
      return v;
   endfunction

   // Mismatches between the recorded enable sequence and 1<<0 .. 1<<(n-1)
   function automatic int seq_errs(input int n);
      int e;
      logic [NCHUNK-1:0] w;
      e = 0;
      if (obs_im_seq.size() != n) e++;
      for (int i = 0; i < obs_im_seq.size() && i < n; i++) begin
         w = NCHUNK'(1) << i;
         if (obs_im_seq[i] !== w) e++;
      end
      return e;
   endfunction

   task automatic drive_job(input int vdly, input int sv_dly, input int im_dly, input int empty_mode,
                            input bit stray, input int no_sv_chunk, input bit busy_start,
                            input int rst_at, input int max_cyc);
      logic [CHUNK_W-1:0] exp_q[$];
      logic [CHUNK_W-1:0] cur;
      logic [CHUNK_W-1:0] exp_din;
      logic [NCHUNK-1:0]  im_tgt = '0;
      logic [NCHUNK-1:0]  prev_im = '0;
      logic [NCHUNK-1:0]  stray_bits = NCHUNK'(4);
      int ld_wait = 0, cur_vdly = vdly, sent = 0, routed = 0;
      int sv_timer = 0, im_timer = 0, stray_phase = 0, cyc = 0, model_cnt = 0, sena_cyc = -1;
      bit model_drain = 0, drain_pending = 0, drain_start_done = 0, done = 0, exp_tdeq;
      obs_sena = 0; obs_tdeq = 0; obs_din_bad = 0; obs_onehot_bad = 0; obs_overlap = 0;
      obs_tdeq_bad = 0; obs_cnt_bad = 0; obs_started_bad = 0; obs_busy_bad = 0;
      obs_first_stall = -1; obs_stall_sena = 0; obs_stray_bad = 0; obs_stray_checked = 0;
      obs_to_cycles = -1; obs_rst_seen = 0; obs_cnt_pre_rst = -1; obs_timed_out = 0;
      obs_rst_nonzero = 1'b1;
      obs_im_seq.delete();
      cur = rand_chunk();
      @(negedge clk);
      start = 1'b1; chunk_valid = 1'b0; s_valid = 1'b0; im_done = '0; t_empty = 1'b0;
      while (!done && cyc < max_cyc) begin
         @(negedge clk);
         cyc++;
         model_drain = model_drain | drain_pending;
         start = 1'b0;
         if (busy_start && cyc == 30) start = 1'b1;
         if (busy_start && model_drain && model_cnt == 40 && !drain_start_done) begin
            start = 1'b1;
            drain_start_done = 1;
         end
         chunk_valid = (ld_wait >= cur_vdly);
         chunk_data  = cur;
         s_valid = 1'b0;
         if (sv_timer > 0) begin
            sv_timer--;
            if (sv_timer == 0) s_valid = 1'b1;
         end
         im_done = '0;
         if (im_timer > 0) begin
            im_timer--;
            if (im_timer == 0) begin
               im_done = im_tgt;
               routed++;
               if (routed == NCHUNK) drain_pending = 1;
            end
         end
         if (stray_phase == 1) begin
            im_done = im_done | stray_bits;
            stray_phase = 2;
         end
         case (empty_mode)
            0:       t_empty = 1'b0;
            1:       t_empty = (cyc % 2 == 1);
            default: t_empty = 1'($urandom_range(0, 1));
         endcase
         #1;
         if (rst_at >= 0 && model_drain && model_cnt == rst_at) begin
            obs_cnt_pre_rst = int'(out_cnt);
            rst = 1'b1;
            #1;
            obs_rst_nonzero = (|s_din) | s_ena | (|im_ena) | t_deq | chunk_ready | (|out_cnt)
                              | started | finished | busy | err;
            obs_rst_seen = 1;
            @(negedge clk);
            rst  = 1'b0;
            done = 1;
         end else begin
            if (s_ena && t_deq) obs_overlap++;
            if ($countones(im_ena) > 1) obs_onehot_bad++;
            if (busy !== ~finished) obs_busy_bad++;
            exp_tdeq = model_drain && !t_empty && (model_cnt < TOTAL);
            if (t_deq !== exp_tdeq) obs_tdeq_bad++;
            if (out_cnt !== 8'(model_cnt)) obs_cnt_bad++;
            if (started !== (model_cnt > 0)) obs_started_bad++;
            if (t_deq) obs_tdeq++;
            if (exp_tdeq) model_cnt++;
            if (s_ena) begin
               obs_sena++;
               if (exp_q.size() == 0) obs_din_bad++;
               else begin
                  exp_din = exp_q.pop_front();
                  if (s_din !== exp_din) obs_din_bad++;
               end
               if (obs_sena - 1 == no_sv_chunk) sena_cyc = cyc;
               else sv_timer = (sv_dly > 0) ? sv_dly : int'($urandom_range(1, 6));
            end
            if (im_ena != '0 && im_ena != prev_im) begin
               obs_im_seq.push_back(im_ena);
               im_tgt   = im_ena;
               im_timer = (im_dly > 0) ? im_dly : int'($urandom_range(1, 6));
               if (stray && im_ena == NCHUNK'(1) && stray_phase == 0) stray_phase = 1;
            end
            prev_im = im_ena;
            if (stray_phase == 2) stray_phase = 3;
            else if (stray_phase == 3) begin
               if (im_ena !== NCHUNK'(1)) obs_stray_bad++;
               obs_stray_checked++;
               stray_phase = 4;
            end
            if (chunk_ready) begin
               if (chunk_valid) begin
                  exp_q.push_back(cur);
                  last_chunk = cur;
                  if (sent == 0) obs_first_stall = ld_wait + 1;
                  sent++;
                  ld_wait  = 0;
                  cur_vdly = 0;
                  cur      = rand_chunk();
               end else begin
                  ld_wait++;
                  if (s_ena) obs_stall_sena++;
               end
            end
            if (finished) begin
               done = 1;
               if (sena_cyc >= 0) obs_to_cycles = cyc - sena_cyc;
            end
         end
      end
      if (!done) obs_timed_out = 1;
      start = 1'b0; chunk_valid = 1'b0; s_valid = 1'b0; im_done = '0; t_empty = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; chunk_valid = 1'b1; chunk_data = '1;
      s_valid = 1'b0; im_done = '0; t_empty = 1'b0;
      #3;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (chunk_ready !== 1'b0) begin errors++; $display("FAIL reset_chunk_ready: got %b want 0", chunk_ready); end
      checks++; if (out_cnt !== 8'd0) begin errors++; $display("FAIL reset_out_cnt: got %0d want 0", out_cnt); end
      checks++; if ({s_ena, t_deq, im_ena, started, finished, err} !== '0) begin
         errors++; $display("FAIL reset_ctrl: got s_ena=%b t_deq=%b im_ena=%h started=%b finished=%b err=%b want all 0",
                            s_ena, t_deq, im_ena, started, finished, err);
      end
      checks++; if (s_din !== '0) begin errors++; $display("FAIL reset_s_din: got nonzero want 0"); end
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      checks++; if ({busy, chunk_ready, s_ena} !== 3'b000) begin
         errors++; $display("FAIL idle_no_start: got busy=%b chunk_ready=%b s_ena=%b want 000", busy, chunk_ready, s_ena);
      end
      chunk_valid = 1'b0;
   endtask

   task automatic test_nominal();
      drive_job(0, 3, 4, 0, 0, -1, 0, -1, 3000);
      checks++; if (obs_timed_out != 0) begin errors++; $display("FAIL nominal_timeout: job did not finish"); end
      checks++; if (obs_sena != 8) begin errors++; $display("FAIL nominal_s_ena: got %0d want 8", obs_sena); end
      checks++; if (seq_errs(8) != 0) begin errors++; $display("FAIL nominal_im_seq: got %0d entries/mismatches want 0x01..0x80", obs_im_seq.size()); end
      checks++; if (obs_tdeq != 128) begin errors++; $display("FAIL nominal_t_deq: got %0d want 128", obs_tdeq); end
      checks++; if (out_cnt !== 8'd128) begin errors++; $display("FAIL nominal_out_cnt: got %0d want 128", out_cnt); end
      checks++; if ({finished, err, started, busy} !== 4'b1010) begin
         errors++; $display("FAIL nominal_flags: got fin=%b err=%b started=%b busy=%b want 1 0 1 0", finished, err, started, busy);
      end
      checks++; if (obs_din_bad != 0) begin errors++; $display("FAIL nominal_s_din: got %0d bad chunks want 0", obs_din_bad); end
      checks++; if (s_din !== last_chunk) begin errors++; $display("FAIL nominal_s_din_hold: s_din differs from last chunk"); end
      checks++; if (obs_tdeq_bad + obs_cnt_bad + obs_started_bad != 0) begin
         errors++; $display("FAIL nominal_drain: got tdeq_bad=%0d cnt_bad=%0d started_bad=%0d want 0", obs_tdeq_bad, obs_cnt_bad, obs_started_bad);
      end
      checks++; if (obs_onehot_bad + obs_overlap + obs_busy_bad != 0) begin
         errors++; $display("FAIL nominal_invariants: got onehot=%0d overlap=%0d busy=%0d want 0", obs_onehot_bad, obs_overlap, obs_busy_bad);
      end
      checks++; if (im_ena !== '0) begin errors++; $display("FAIL nominal_im_ena_end: got %h want 0", im_ena); end
   endtask

   task automatic test_backpressure();
      drive_job(10, 0, 0, 1, 0, -1, 0, -1, 3000);
      checks++; if (obs_first_stall != 11) begin errors++; $display("FAIL bp_ready_cycles: got %0d want 11", obs_first_stall); end
      checks++; if (obs_stall_sena != 0) begin errors++; $display("FAIL bp_s_ena_in_stall: got %0d want 0", obs_stall_sena); end
      checks++; if (obs_tdeq != 128) begin errors++; $display("FAIL bp_t_deq: got %0d want 128", obs_tdeq); end
      checks++; if (out_cnt !== 8'd128) begin errors++; $display("FAIL bp_out_cnt: got %0d want 128", out_cnt); end
      checks++; if (obs_tdeq_bad + obs_cnt_bad + obs_din_bad != 0) begin
         errors++; $display("FAIL bp_drain: got tdeq_bad=%0d cnt_bad=%0d din_bad=%0d want 0", obs_tdeq_bad, obs_cnt_bad, obs_din_bad);
      end
   endtask

   task automatic test_stray_done();
      drive_job(0, 0, 5, 2, 1, -1, 0, -1, 3000);
      checks++; if (obs_stray_checked != 1) begin errors++; $display("FAIL stray_window: got %0d checks want 1", obs_stray_checked); end
      checks++; if (obs_stray_bad != 0) begin errors++; $display("FAIL stray_im_ena: got %0d bad want 0 (im_ena stays 0x01)", obs_stray_bad); end
      checks++; if (seq_errs(8) != 0) begin errors++; $display("FAIL stray_im_seq: got %0d entries want 0x01..0x80", obs_im_seq.size()); end
      checks++; if (out_cnt !== 8'd128 || finished !== 1'b1) begin
         errors++; $display("FAIL stray_end: got out_cnt=%0d fin=%b want 128 1", out_cnt, finished);
      end
   endtask

   task automatic test_timeout();
      drive_job(0, 3, 4, 2, 0, 2, 0, -1, 3000);
      checks++; if (obs_timed_out != 0) begin errors++; $display("FAIL to_no_finish: job did not finish"); end
      checks++; if ({err, finished} !== 2'b11) begin errors++; $display("FAIL to_flags: got err=%b fin=%b want 1 1", err, finished); end
      checks++; if (im_ena !== '0) begin errors++; $display("FAIL to_im_ena: got %h want 0", im_ena); end
      checks++; if (out_cnt !== 8'd0 || started !== 1'b0) begin
         errors++; $display("FAIL to_drain: got out_cnt=%0d started=%b want 0 0", out_cnt, started);
      end
      checks++; if (obs_to_cycles != TIMEOUT) begin errors++; $display("FAIL to_cycles: got %0d want %0d", obs_to_cycles, TIMEOUT); end
      checks++; if (obs_sena != 3 || seq_errs(2) != 0) begin
         errors++; $display("FAIL to_progress: got s_ena=%0d im_seq=%0d want 3 2", obs_sena, obs_im_seq.size());
      end
   endtask

   task automatic test_back_to_back();
      drive_job(0, 0, 0, 2, 0, -1, 0, -1, 3000);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL b2b_err_cleared: got %b want 0", err); end
      checks++; if (out_cnt !== 8'd128 || finished !== 1'b1) begin
         errors++; $display("FAIL b2b_end: got out_cnt=%0d fin=%b want 128 1", out_cnt, finished);
      end
      checks++; if (obs_cnt_bad + obs_tdeq_bad + obs_din_bad != 0) begin
         errors++; $display("FAIL b2b_model: got cnt_bad=%0d tdeq_bad=%0d din_bad=%0d want 0", obs_cnt_bad, obs_tdeq_bad, obs_din_bad);
      end
   endtask

   task automatic test_reset_mid_drain();
      drive_job(0, 0, 0, 2, 0, -1, 0, 50, 3000);
      checks++; if (obs_rst_seen != 1 || obs_cnt_pre_rst != 50) begin
         errors++; $display("FAIL rst_point: got seen=%0d out_cnt=%0d want 1 50", obs_rst_seen, obs_cnt_pre_rst);
      end
      checks++; if (obs_rst_nonzero !== 1'b0) begin errors++; $display("FAIL rst_outputs: got nonzero want all 0"); end
      repeat (4) @(negedge clk);
      checks++; if (busy !== 1'b0 || chunk_ready !== 1'b0) begin
         errors++; $display("FAIL rst_idle: got busy=%b chunk_ready=%b want 0 0", busy, chunk_ready);
      end
      drive_job(0, 0, 0, 0, 0, -1, 0, -1, 3000);
      checks++; if (out_cnt !== 8'd128 || finished !== 1'b1 || obs_sena != 8) begin
         errors++; $display("FAIL rst_rerun: got out_cnt=%0d fin=%b s_ena=%0d want 128 1 8", out_cnt, finished, obs_sena);
      end
   endtask

   task automatic test_start_while_busy();
      drive_job(0, 3, 4, 0, 0, -1, 1, -1, 3000);
      checks++; if (obs_sena != 8 || seq_errs(8) != 0) begin
         errors++; $display("FAIL busy_start_seq: got s_ena=%0d im_seq=%0d want 8 8", obs_sena, obs_im_seq.size());
      end
      checks++; if (obs_tdeq != 128 || out_cnt !== 8'd128) begin
         errors++; $display("FAIL busy_start_cnt: got t_deq=%0d out_cnt=%0d want 128 128", obs_tdeq, out_cnt);
      end
      checks++; if (obs_cnt_bad != 0) begin errors++; $display("FAIL busy_start_out_cnt_track: got %0d bad want 0", obs_cnt_bad); end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_backpressure();
      test_stray_done();
      test_timeout();
      test_back_to_back();
      test_reset_mid_drain();
      test_start_while_busy();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
